// File: rtl/wisc_pkg.sv
// ----------------------------------------------------------------------------
// wisc_pkg
// Shared definitions for the WISC single-cycle datapath control blocks:
// control-flow opcodes, branch condition codes and the PC-owner FSM states.
// ----------------------------------------------------------------------------
package wisc_pkg;

  // Control-flow opcodes (instr[15:12]); every other opcode is non-control.
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Branch condition codes (instr[11:9]).
  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OV     = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage : wisc_pkg

// File: rtl/branch_cond_eval.sv
// ----------------------------------------------------------------------------
// branch_cond_eval
// Combinational branch condition evaluator. Flags arriving here are already
// the effective (bypassed) values.
//   ccc_i   condition code from instr[11:9]
//   z_i     effective zero flag
//   v_i     effective overflow flag
//   n_i     effective negative flag
//   taken_o condition holds
// ----------------------------------------------------------------------------
module branch_cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] ccc_i,
  input  logic       z_i,
  input  logic       v_i,
  input  logic       n_i,
  output logic       taken_o
);

  // NOTE: every output of an always_comb gets a default assignment first so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    taken_o = 1'b0;
    case (ccc_i)
      CC_NE:     taken_o = ~z_i;
      CC_EQ:     taken_o = z_i;
      CC_GT:     taken_o = ~z_i & ~n_i;
      CC_LT:     taken_o = n_i;
      CC_GTE:    taken_o = z_i | (~z_i & ~n_i);
      CC_LTE:    taken_o = n_i | z_i;
      CC_OV:     taken_o = v_i;
      CC_UNCOND: taken_o = 1'b1;
      default:   taken_o = 1'b0;
    endcase
  end

endmodule : branch_cond_eval

// File: rtl/pc_control.sv
// ----------------------------------------------------------------------------
// pc_control
// Program counter owner and flag consumer for the single-cycle WISC datapath.
// Resolves B/BR in the same cycle using flags bypassed from any flag write in
// flight, selects the next PC, handles HLT and counts taken branches with a
// saturating counter.
//   clk, rst_n            clock (rising edge), async active-low reset
//   stall                 hold PC, FSM and counter this cycle
//   instr                 instruction at the current pc
//   rs_data               BR target register value
//   Z, V, N               registered flags
//   {Z,V,N}_en/_set       flag writes issued this cycle (bypass source)
//   pc, pc_plus2          current PC and PC+2 (PCS write-back value)
//   branch_taken          B/BR taken this cycle (combinational)
//   halted                processor halted (registered)
//   taken_cnt             saturating taken-branch count
// ----------------------------------------------------------------------------
module pc_control
  import wisc_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [15:0]      instr,
  input  logic [15:0]      rs_data,
  input  logic             Z,
  input  logic             V,
  input  logic             N,
  input  logic             Z_en,
  input  logic             Z_set,
  input  logic             V_en,
  input  logic             V_set,
  input  logic             N_en,
  input  logic             N_set,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus2,
  output logic             branch_taken,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [PC_W-1:0]  pc_q, pc_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]      opcode;
  logic            is_branch;
  logic            cond_taken;
  logic            z_eff, v_eff, n_eff;
  logic [PC_W-1:0] b_offset;
  logic [PC_W-1:0] b_target;
  logic [PC_W-1:0] br_target;

  assign opcode    = instr[15:12];
  assign is_branch = (opcode == OP_B) || (opcode == OP_BR);

  // Zero-latency bypass: a flag being written this cycle overrides the
  // registered copy, individually per flag.
  assign z_eff = Z_en ? Z_set : Z;
  assign v_eff = V_en ? V_set : V;
  assign n_eff = N_en ? N_set : N;

  branch_cond_eval u_cond (
    .ccc_i   (instr[11:9]),
    .z_i     (z_eff),
    .v_i     (v_eff),
    .n_i     (n_eff),
    .taken_o (cond_taken)
  );

  assign pc_plus2  = pc_q + PC_W'(2);
  // Word offset: sign-extend the 9-bit immediate, then scale to bytes.
  assign b_offset  = {{(PC_W-9){instr[8]}}, instr[8:0]} << 1;
  assign b_target  = pc_plus2 + b_offset;
  assign br_target = PC_W'(rs_data);

  // rst_n is included so the strobe is low for the whole reset window, not
  // just after the registers have cleared.
  assign branch_taken = rst_n && (state_q == ST_RUN) && !stall &&
                        is_branch && cond_taken;

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (state_q == ST_RUN && !stall) begin
      case (opcode)
        OP_HLT:  state_d = ST_HALT;            // pc stays on the HLT address
        OP_B:    pc_d    = cond_taken ? b_target  : pc_plus2;
        OP_BR:   pc_d    = cond_taken ? br_target : pc_plus2;
        OP_PCS:  pc_d    = pc_plus2;           // pc_plus2 is the write-back value
        default: pc_d    = pc_plus2;
      endcase
    end

    if (branch_taken && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign halted    = (state_q == ST_HALT);
  assign taken_cnt = cnt_q;

endmodule : pc_control

// File: tb/tb_pc_control.sv
// ----------------------------------------------------------------------------
// tb_pc_control
// Scoreboarded bench for pc_control. Each stimulus cycle pushes the expected
// outputs computed by an arithmetic reference model; a monitor on the falling
// edge pops and compares. The counter is built narrow so saturation is
// reachable in a short run.
// ----------------------------------------------------------------------------
module tb_pc_control;

  localparam int PC_W    = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int RST_PC  = 0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall;
  logic [15:0]       instr;
  logic [15:0]       rs_data;
  logic              Z, V, N;
  logic              Z_en, Z_set, V_en, V_set, N_en, N_set;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_plus2;
  logic              branch_taken;
  logic              halted;
  logic [CNT_W-1:0]  taken_cnt;

  pc_control #(
    .PC_W     (PC_W),
    .RESET_PC (16'h0000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .instr        (instr),
    .rs_data      (rs_data),
    .Z            (Z),
    .V            (V),
    .N            (N),
    .Z_en         (Z_en),
    .Z_set        (Z_set),
    .V_en         (V_en),
    .V_set        (V_set),
    .N_en         (N_en),
    .N_set        (N_set),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .branch_taken (branch_taken),
    .halted       (halted),
    .taken_cnt    (taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int pc2;
    bit taken;
    bit halted;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state.
  int m_pc     = RST_PC;
  bit m_halted = 1'b0;
  int m_cnt    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s (vector %0d): got %0h expected %0h", nm, n_vec, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      check("pc",           32'(pc),           32'(e.pc));
      check("pc_plus2",     32'(pc_plus2),     32'(e.pc2));
      check("branch_taken", 32'(branch_taken), 32'(e.taken));
      check("halted",       32'(halted),       32'(e.halted));
      check("taken_cnt",    32'(taken_cnt),    32'(e.cnt));
    end
  end

  function automatic bit cond_holds(input int ccc, input bit z, input bit v, input bit n);
    case (ccc)
      0:       return !z;
      1:       return z;
      2:       return !z && !n;
      3:       return n;
      4:       return z || (!z && !n);
      5:       return n || z;
      6:       return v;
      default: return 1'b1;
    endcase
  endfunction

  // Drive one cycle (called just after a rising edge), record the expected
  // outputs for this cycle, advance the model, then move to the next edge.
  task automatic apply(input bit r, input bit s, input logic [15:0] ins,
                       input logic [15:0] rs, input logic [2:0] zvn,
                       input logic [2:0] en, input logic [2:0] set);
    exp_t e;
    int   op, ccc, imm;
    bit   zf, vf, nf, tk;
    rst_n = r; stall = s; instr = ins; rs_data = rs;
    {Z, V, N} = zvn;
    {Z_en, V_en, N_en} = en;
    {Z_set, V_set, N_set} = set;

    if (!r) begin
      m_pc = RST_PC; m_halted = 1'b0; m_cnt = 0;
      e = '{pc: RST_PC, pc2: RST_PC + 2, taken: 1'b0, halted: 1'b0, cnt: 0};
      sb.push_back(e);
    end else begin
      zf  = en[2] ? set[2] : zvn[2];
      vf  = en[1] ? set[1] : zvn[1];
      nf  = en[0] ? set[0] : zvn[0];
      op  = int'(ins) >> 12;
      ccc = (int'(ins) >> 9) & 7;
      imm = int'(ins) & 'h1FF;
      if (imm >= 256) imm -= 512;
      tk  = !m_halted && !s && (op == 12 || op == 13) && cond_holds(ccc, zf, vf, nf);
      e   = '{pc: m_pc, pc2: (m_pc + 2) & 'hFFFF, taken: tk, halted: m_halted, cnt: m_cnt};
      sb.push_back(e);
      if (!m_halted && !s) begin
        if (op == 15)     m_halted = 1'b1;
        else if (tk)      m_pc = (op == 12) ? ((m_pc + 2 + 2 * imm) & 'hFFFF) : int'(rs);
        else              m_pc = (m_pc + 2) & 'hFFFF;
      end
      if (tk && m_cnt < CNT_MAX) m_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic nop();
    apply(1, 0, 16'h0000, 16'h0000, 3'b000, 3'b000, 3'b000);
  endtask

  task automatic jump(input logic [15:0] addr);
    apply(1, 0, 16'hDE00, addr, 3'b000, 3'b000, 3'b000);
  endtask

  initial begin
    logic [15:0] ins;
    int          k;
    rst_n = 1'b0; stall = 1'b0; instr = 16'h0; rs_data = 16'h0;
    {Z, V, N} = 3'b000; {Z_en, V_en, N_en} = 3'b000; {Z_set, V_set, N_set} = 3'b000;
    @(posedge clk); #1;

    // Reset: a taken-looking BR must not assert branch_taken under reset.
    apply(0, 0, 16'hDE00, 16'h5555, 3'b000, 3'b000, 3'b000);
    apply(0, 0, 16'hDE00, 16'h5555, 3'b000, 3'b000, 3'b000);
    // Increment from reset.
    repeat (3) nop();

    // B EQ with Z bypassed to 1 over a registered Z=0.
    jump(16'h0010);
    apply(1, 0, 16'hC203, 16'h0, 3'b000, 3'b100, 3'b100);
    // B NE with registered Z=1, no bypass: not taken.
    apply(1, 0, 16'hC005, 16'h0, 3'b100, 3'b000, 3'b000);
    // Partial bypass: only N overridden, LT taken.
    apply(1, 0, 16'hC601, 16'h0, 3'b100, 3'b001, 3'b001);
    // Negative offset back to zero, and PC wrap-around.
    jump(16'h0002);
    apply(1, 0, 16'hCFFE, 16'h0, 3'b000, 3'b000, 3'b000);
    jump(16'hFFFE);
    nop();
    nop();

    // BR held by stall for two cycles, then resolves once.
    apply(1, 1, 16'hDE00, 16'h1234, 3'b000, 3'b000, 3'b000);
    apply(1, 1, 16'hDE00, 16'h1234, 3'b000, 3'b000, 3'b000);
    apply(1, 0, 16'hDE00, 16'h1234, 3'b000, 3'b000, 3'b000);
    nop();

    // HLT under stall does not halt; then halt and stay frozen.
    jump(16'h0040);
    apply(1, 1, 16'hF000, 16'h0, 3'b000, 3'b000, 3'b000);
    apply(1, 0, 16'hF000, 16'h0, 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 5; i++)
      apply(1, 1'($urandom_range(0, 1)), 16'hDE00, 16'($urandom), 3'b111, 3'b000, 3'b000);
    // Reset mid-halt returns to RUN at the reset PC.
    apply(0, 0, 16'h0000, 16'h0, 3'b000, 3'b000, 3'b000);
    nop();
    nop();

    // Counter saturation.
    for (int i = 0; i < CNT_MAX + 4; i++) jump(16'(i * 4));

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 9);
      ins = 16'($urandom);
      if (k <= 2)      ins[15:12] = 4'hC;
      else if (k <= 4) ins[15:12] = 4'hD;
      else if (k == 5) ins[15:12] = 4'hE;
      else if (k == 6) ins[15:12] = ($urandom_range(0, 9) == 0) ? 4'hF : 4'h0;
      else             ins[15:12] = 4'($urandom_range(0, 11));
      apply(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) == 0), ins,
            16'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pc_control
